// File: rtl/conv_writeback_if.sv
// conv_writeback_if: result stream and output SRAM port bundle.
// slave = writeback block, master = producer / SRAM side.
interface conv_writeback_if #(
  parameter int X_MAX       = 60,
  parameter int Y_MAX       = 60,
  parameter int PIXEL_DEPTH = 8
);
  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;

  logic                   res_valid;
  logic [PIXEL_DEPTH-1:0] res_pixel;
  logic                   res_ready;
  logic [XW-1:0]          x_addr_out;
  logic [YW-1:0]          y_addr_out;
  logic                   wen_out;
  logic [PIXEL_DEPTH-1:0] wdat_out;
  logic                   wr_busy;

  modport slave (
    input  res_valid,
    input  res_pixel,
    input  wr_busy,
    output res_ready,
    output x_addr_out,
    output y_addr_out,
    output wen_out,
    output wdat_out
  );

  modport master (
    output res_valid,
    output res_pixel,
    output wr_busy,
    input  res_ready,
    input  x_addr_out,
    input  y_addr_out,
    input  wen_out,
    input  wdat_out
  );
endinterface

// File: rtl/conv_writeback.sv
// conv_writeback: buffers filtered pixels and writes them to the
// output SRAM in serpentine order, flagging frame completion.
module conv_writeback #(
  parameter int X_MAX       = 60,
  parameter int Y_MAX       = 60,
  parameter int PIXEL_DEPTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_trans,
  input  logic [7:0]      out_width,
  input  logic [7:0]      out_height,
  conv_writeback_if.slave bus,
  output logic            frame_done,
  output logic            drop_err
);
  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PIXEL_DEPTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]          rd_q;
  logic [PW-1:0]          wr_q;
  logic [PW:0]            cnt_q;

  logic [7:0]    w_q;
  logic [7:0]    h_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  // dir: 0 = moving right, 1 = moving left
  logic          dir_q, dir_d;
  logic          fd_q;
  logic          de_q;

  logic       run;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       last;
  logic       zero_dim;
  logic       drop;
  logic [7:0] x_ext;
  logic [7:0] y_ext;

  assign run      = (state_q == S_RUN);
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign x_ext    = 8'(x_q);
  assign y_ext    = 8'(y_q);
  assign zero_dim = (out_width == 8'd0) || (out_height == 8'd0);
  assign push     = !new_trans && bus.res_valid && run && !full;
  assign pop      = !new_trans && run && !empty && !bus.wr_busy;
  assign drop     = !new_trans && run && bus.res_valid && full;
  assign last     = (y_ext == h_q - 8'd1) &&
                    (h_q[0] ? (x_ext == w_q - 8'd1)
                            : (x_ext == 8'd0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: new_trans wins over everything else
  always_comb begin
    state_d = state_q;
    if (new_trans) begin
      state_d = zero_dim ? S_DONE : S_RUN;
    end else begin
      unique case (state_q)
        S_RUN:   if (pop && last) state_d = S_DONE;
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: handshake, write port and status flags
  always_comb begin
    bus.res_ready  = run && !full;
    bus.wen_out    = run && !empty;
    bus.wdat_out   = mem_q[rd_q];
    bus.x_addr_out = x_q;
    bus.y_addr_out = y_q;
    frame_done     = fd_q;
    drop_err       = de_q;
  end

  // Serpentine step to the next output position
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    if (!dir_q) begin
      if (x_ext < w_q - 8'd1) begin
        x_d = x_q + XW'(1);
      end else begin
        y_d   = y_q + YW'(1);
        dir_d = 1'b1;
      end
    end else begin
      if (x_q != '0) begin
        x_d = x_q - XW'(1);
      end else begin
        y_d   = y_q + YW'(1);
        dir_d = 1'b0;
      end
    end
  end

  // FIFO, position, frame geometry and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      w_q   <= '0;
      h_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      dir_q <= 1'b0;
      fd_q  <= 1'b0;
      de_q  <= 1'b0;
    end else if (new_trans) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      w_q   <= out_width;
      h_q   <= out_height;
      x_q   <= '0;
      y_q   <= '0;
      dir_q <= 1'b0;
      fd_q  <= zero_dim;
      de_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= bus.res_pixel;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q  <= rd_q + PW'(1);
        x_q   <= x_d;
        y_q   <= y_d;
        dir_q <= dir_d;
        if (last) fd_q <= 1'b1;
      end
      if (push && !pop) cnt_q <= cnt_q + (PW+1)'(1);
      if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
      if (drop) de_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_writeback.sv
// tb_conv_writeback: directed and randomized frames checked
// against a queue-based serpentine reference model.
module tb_conv_writeback;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_trans = 1'b0;
  logic [7:0] out_width = 8'd0;
  logic [7:0] out_height = 8'd0;
  logic       frame_done;
  logic       drop_err;

  conv_writeback_if bus ();

  conv_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .new_trans  (new_trans),
    .out_width  (out_width),
    .out_height (out_height),
    .bus        (bus),
    .frame_done (frame_done),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // reference model
  bit           mrun;
  bit           mfd;
  bit           mdrop;
  byte unsigned q[$];
  int           k;
  int           mw;
  int           mh;
  int           xs[$];
  int           ys[$];
  bit [7:0]     pix;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit mrdy();
    return mrun && (q.size() < 4);
  endfunction

  task automatic model_start(input int w, input int h);
    mw = w;
    mh = h;
    k = 0;
    mdrop = 1'b0;
    q.delete();
    xs.delete();
    ys.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        xs.push_back((r % 2 == 0) ? c : w - 1 - c);
        ys.push_back(r);
      end
    end
    mrun = (w * h != 0);
    mfd = !mrun;
  endtask

  task automatic check_all();
    bit we;
    we = mrun && (q.size() > 0);
    chk("res_ready", bus.res_ready, mrdy());
    chk("wen_out", bus.wen_out, we);
    chk("frame_done", frame_done, mfd);
    chk("drop_err", drop_err, mdrop);
    if (we) begin
      chk("wdat_out", bus.wdat_out, q[0]);
      chk("x_addr", bus.x_addr_out, xs[k]);
      chk("y_addr", bus.y_addr_out, ys[k]);
    end
  endtask

  // check current outputs, drive one cycle, advance the model
  task automatic cyc(input bit nt, input int w, input int h,
                     input bit v, input bit busy);
    bit rdy;
    bit acc;
    check_all();
    new_trans = nt;
    out_width = 8'(w);
    out_height = 8'(h);
    bus.res_valid = v;
    bus.res_pixel = pix;
    bus.wr_busy = busy;
    if (nt) begin
      model_start(w, h);
    end else begin
      rdy = mrdy();
      acc = mrun && (q.size() > 0) && !busy;
      if (mrun && v && !rdy) mdrop = 1'b1;
      if (acc) begin
        void'(q.pop_front());
        k++;
        if (k == mw * mh) begin
          mrun = 1'b0;
          mfd = 1'b1;
        end
      end
      if (v && rdy) begin
        q.push_back(pix);
        pix++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_done(input int vp, input int bp, input bit obey);
    int n;
    bit v;
    bit b;
    n = 0;
    while (mrun && n < 2000) begin
      v = ($urandom_range(0, 99) < vp) && (!obey || mrdy());
      b = ($urandom_range(0, 99) < bp);
      cyc(1'b0, mw, mh, v, b);
      n++;
    end
    chk("frame_timeout", {31'd0, mrun}, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, mw, mh, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_trans = 1'b0;
    bus.res_valid = 1'b1;
    bus.wr_busy = 1'b0;
    @(negedge clk);
    mrun = 1'b0;
    mfd = 1'b0;
    mdrop = 1'b0;
    k = 0;
    q.delete();
    chk("rst_res_ready", bus.res_ready, 0);
    chk("rst_wen_out", bus.wen_out, 0);
    chk("rst_x_addr", bus.x_addr_out, 0);
    chk("rst_y_addr", bus.y_addr_out, 0);
    chk("rst_wdat_out", bus.wdat_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_drop_err", drop_err, 0);
    rst = 1'b0;
    bus.res_valid = 1'b0;
  endtask

  initial begin
    int w;
    int h;
    bus.res_valid = 1'b0;
    bus.res_pixel = '0;
    bus.wr_busy = 1'b0;
    pix = 8'd0;
    mw = 0;
    mh = 0;

    // reset, then res_valid in IDLE is ignored
    do_reset();
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);

    // 3x2 frame, continuous source, no stalls
    pix = 8'd10;
    cyc(1'b1, 3, 2, 1'b0, 1'b0);
    run_done(100, 0, 1'b1);

    // same frame, wr_busy high for cycles 2..5
    pix = 8'd10;
    cyc(1'b1, 3, 2, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++)
      cyc(1'b0, 3, 2, mrdy(), (c >= 2 && c <= 5));
    run_done(100, 0, 1'b1);

    // source ignores res_ready while the FIFO is full
    pix = 8'd40;
    cyc(1'b1, 3, 2, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) cyc(1'b0, 3, 2, 1'b1, 1'b1);
    run_done(100, 0, 1'b0);

    // new_trans after 3 writes with 2 pixels buffered
    pix = 8'd70;
    cyc(1'b1, 3, 2, 1'b0, 1'b0);
    cyc(1'b0, 3, 2, 1'b1, 1'b1);
    cyc(1'b0, 3, 2, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) cyc(1'b0, 3, 2, 1'b1, 1'b0);
    cyc(1'b1, 3, 2, 1'b1, 1'b0);
    run_done(100, 0, 1'b1);

    // single-column frame
    cyc(1'b1, 1, 3, 1'b0, 1'b0);
    run_done(100, 0, 1'b1);

    // zero-size frames go straight to DONE
    cyc(1'b1, 0, 5, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 0, 5, 1'b1, 1'b0);
    cyc(1'b1, 4, 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 4, 0, 1'b1, 1'b0);

    // full-width frame, odd height
    cyc(1'b1, 60, 3, 1'b0, 1'b0);
    run_done(90, 20, 1'b1);

    // randomized frames with random valid/stall patterns
    for (int f = 0; f < 8; f++) begin
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 6);
      pix = 8'($urandom);
      cyc(1'b1, w, h, 1'b0, 1'b0);
      run_done($urandom_range(30, 100), $urandom_range(0, 60),
               (f % 3) != 2);
    end

    // reset mid-frame
    pix = 8'd200;
    cyc(1'b1, 4, 3, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) cyc(1'b0, 4, 3, 1'b1, c[0]);
    do_reset();
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/conv_writeback.md
# conv_writeback

Write-side counterpart of the convolution window loader. It accepts filtered pixels from the gaussian convolution stage over a valid/ready handshake and buffers them in a small FIFO. It writes them to the output image SRAM in the same serpentine order the window traverses: right along even rows, down, left along odd rows. It tracks its own output position, absorbs SRAM stalls, and flags frame completion.

## Interface
- X_MAX, 60, max output image width in pixels
- Y_MAX, 60, max output image height in pixels
- PIXEL_DEPTH, 8, bits per pixel
- FIFO_DEPTH, 4, result buffer entries (power of two, ≥2)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- new_trans  in  1  start of frame: flush and restart at (0,0)
- out_width  in  8  result columns this frame (0..X_MAX), sampled on new_trans
- out_height  in  8  result rows this frame (0..Y_MAX), sampled on new_trans
- res_valid  in  1  result pixel offered
- res_pixel  in  PIXEL_DEPTH  result pixel value
- res_ready  out  1  block can accept a pixel this cycle
- x_addr_out  out  $clog2(X_MAX)+1  output SRAM column address
- y_addr_out  out  $clog2(Y_MAX)+1  output SRAM row address
- wen_out  out  1  write request
- wdat_out  out  PIXEL_DEPTH  write data
- wr_busy  in  1  SRAM cannot accept a write this cycle
- frame_done  out  1  level; last pixel of the frame written
- drop_err  out  1  sticky; res_valid seen while res_ready low in RUN

## Operation
- States: IDLE, RUN, DONE. rst → IDLE from any state, mid-frame included.
- new_trans in any state → RUN. On the same edge:
  - latch out_width and out_height
  - empty the FIFO
  - pos=(0,0), dir=RIGHT
  - clear frame_done and drop_err
- If the latched width or height is 0, new_trans goes to DONE instead, with frame_done=1.
- new_trans has priority: a res_valid in the same cycle is discarded and does not set drop_err.
- res_ready = (state==RUN) && FIFO not full. A push happens when res_valid && res_ready.
- In RUN with res_valid && !res_ready, drop_err ← 1. In IDLE and DONE, res_valid is ignored.
- wen_out = (state==RUN) && FIFO not empty. wdat_out = FIFO head. Addresses = pos registers.
- A write is accepted when wen_out && !wr_busy. On acceptance: pop the FIFO and advance pos.
- Position advance:
  - dir RIGHT: x<W-1 → x+1; else y+1, dir←LEFT.
  - dir LEFT: x>0 → x-1; else y+1, dir←RIGHT.
  - W=1: x stays 0; every accept increments y.
- The accept at the last position (y==H-1, with x==W-1 when H odd or x==0 when H even) goes to DONE and sets frame_done=1.
- DONE holds until new_trans or rst. In DONE, res_ready=0, wen_out=0, and leftover FIFO contents are ignored.
- Push and pop in the same cycle leave the FIFO count unchanged. Addresses are zero-extended to the port widths.

## Timing
- Reset values:
  - state=IDLE, FIFO empty, pos=(0,0), dir=RIGHT
  - res_ready=0, wen_out=0, x_addr_out=0, y_addr_out=0, wdat_out=0
  - frame_done=0, drop_err=0
- Push latency: pixel pushed at edge N → wen_out high with that pixel from cycle N+1.
- Throughput: 1 pixel/cycle while wr_busy is low.
- While wr_busy is high, wen_out, wdat_out and the addresses hold stable.
- frame_done rises on the edge after the final accepted write.
- res_ready falls in the cycle the FIFO reaches FIFO_DEPTH entries. It rises the cycle after a pop frees an entry.

## Test plan
- 3x2 frame, res_valid continuous, wr_busy=0 → writes at (0,0),(1,0),(2,0),(2,1),(1,1),(0,1) carrying values 10..15 in order; frame_done=1 one cycle after the 6th accept.
- Same frame, wr_busy high for cycles 2–5 → wen_out, data and address hold; FIFO fills to 4; res_ready=0; no drop_err if the source obeys res_ready; write order unchanged.
- Source ignores res_ready while the FIFO is full → drop_err=1 and stays 1 until the next new_trans; the accepted pixel sequence is unaffected.
- new_trans after 3 of 6 writes with 2 pixels buffered → FIFO flushed; next write at (0,0); frame_done=0.
- out_width=1, out_height=3 → writes at (0,0),(0,1),(0,2), then frame_done=1. out_width=0 → DONE immediately, no writes.
- rst asserted mid-frame → next cycle all outputs at reset values, state IDLE, res_ready=0.
